// File: rtl/otp_pad_engine.sv
// One-time-pad cipher engine with a bank of LFSR-filled pads and per-slot reuse tracking.
// Each pad may encrypt once and must then be consumed by one decrypt, which refills it.
module otp_pad_engine #(
    parameter int          DATA_W    = 8,
    parameter int          IDX_W     = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_index,
    input  logic              in_decrypt,
    input  logic              key_we,
    input  logic [IDX_W-1:0]  key_index,
    input  logic [DATA_W-1:0] key_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_err,
    output logic              busy_init
);
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [DATA_W-1:0] pad_q [DEPTH];
    logic [DATA_W-1:0] pad_d [DEPTH];
    logic [DEPTH-1:0]  issued_q, issued_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_index_q, out_index_d;
    logic              out_err_q, out_err_d;

    logic [DATA_W-1:0] draw_s;
    logic              accept_s;
    logic              slot_issued_s;
    logic              legal_s;
    logic [DATA_W-1:0] xor_s;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    assign draw_s        = lfsr_q[DATA_W-1:0];
    assign in_ready      = (state_q == ST_RUN) && !key_we && (!out_valid_q || out_ready);
    assign accept_s      = in_valid && in_ready;
    assign slot_issued_s = issued_q[in_index];
    // Encrypt needs a FRESH pad, decrypt needs an ISSUED one.
    assign legal_s       = in_decrypt ? slot_issued_s : !slot_issued_s;
    assign xor_s         = in_data ^ pad_q[in_index];

    assign busy_init = (state_q == ST_INIT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_err   = out_err_q;

    // Next-state for the top FSM, pad bank and slot lifecycle.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        pad_d      = pad_q;
        issued_d   = issued_q;
        lfsr_d     = lfsr_step(lfsr_q);
        case (state_q)
            ST_INIT: begin
                pad_d[init_cnt_q]    = draw_s;
                issued_d[init_cnt_q] = 1'b0;
                init_cnt_d           = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (key_we) begin
                    pad_d[key_index]    = key_data;
                    issued_d[key_index] = 1'b0;
                end else if (accept_s && legal_s) begin
                    if (in_decrypt) begin
                        pad_d[in_index]    = draw_s;
                        issued_d[in_index] = 1'b0;
                    end else begin
                        issued_d[in_index] = 1'b1;
                    end
                end else begin
                    issued_d = issued_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Single-stage output register; holds its contents under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_err_d   = out_err_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_index_d = in_index;
            if (legal_s) begin
                out_data_d = xor_s;
                out_err_d  = 1'b0;
            end else begin
                out_data_d = '0;
                out_err_d  = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control and output state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            lfsr_q      <= LFSR_SEED;
            issued_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            lfsr_q      <= lfsr_d;
            issued_q    <= issued_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_err_q   <= out_err_d;
        end
    end

    // Pad storage; every slot is rewritten during INIT after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                pad_q[k] <= '0;
            end
        end else begin
            pad_q <= pad_d;
        end
    end

endmodule

// File: tb/tb_otp_pad_engine.sv
// Self-checking bench for otp_pad_engine: directed scenarios plus random traffic
// against a cycle-level reference model, and a short run of a 16-bit/4-slot instance.
module tb_otp_pad_engine;
    localparam int DEPTH = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_decrypt, key_we, out_ready;
    logic [7:0] in_data, key_data;
    logic [2:0] in_index, key_index;
    logic       in_ready, out_valid, out_err, busy_init;
    logic [7:0] out_data;
    logic [2:0] out_index;

    otp_pad_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_index(in_index), .in_decrypt(in_decrypt),
        .key_we(key_we), .key_index(key_index), .key_data(key_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_err(out_err), .busy_init(busy_init)
    );

    logic        r16, v16, dec16, kwe16, ordy16;
    logic [15:0] d16, kd16;
    logic [1:0]  i16, ki16;
    logic        rdy16, ov16, oe16, busy16;
    logic [15:0] od16;
    logic [1:0]  oi16;

    otp_pad_engine #(.DATA_W(16), .IDX_W(2)) dut16 (
        .clk(clk), .rst(r16), .in_valid(v16), .in_ready(rdy16),
        .in_data(d16), .in_index(i16), .in_decrypt(dec16),
        .key_we(kwe16), .key_index(ki16), .key_data(kd16),
        .out_valid(ov16), .out_ready(ordy16), .out_data(od16),
        .out_index(oi16), .out_err(oe16), .busy_init(busy16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] m_lfsr;
    bit          m_run;
    int          m_cnt;
    logic [7:0]  m_pad [DEPTH];
    bit          m_iss [DEPTH];
    bit          m_ov, m_oe;
    logic [7:0]  m_od;
    logic [2:0]  m_oi;
    logic [7:0]  m_last_draw;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    task automatic model_reset();
        m_lfsr = SEED;
        m_run  = 1'b0;
        m_cnt  = 0;
        for (int k = 0; k < DEPTH; k++) m_iss[k] = 1'b0;
        m_ov = 1'b0; m_oe = 1'b0; m_od = 8'h00; m_oi = 3'd0;
    endtask

    // One clock: check ready, advance the model at the edge, check outputs after it.
    task automatic step();
        bit         exp_ready, acc, was_rst;
        logic [7:0] draw;
        int         s;
        #1;
        was_rst   = rst;
        exp_ready = m_run && !key_we && (!m_ov || out_ready);
        if (!rst) begin
            check_eq("in_ready", in_ready, exp_ready);
            check_eq("busy_init", busy_init, !m_run);
        end
        acc = !rst && in_valid && exp_ready;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            draw = m_lfsr[7:0];
            if (!m_run) begin
                m_pad[m_cnt] = draw;
                m_iss[m_cnt] = 1'b0;
                m_cnt++;
                if (m_cnt == DEPTH) m_run = 1'b1;
            end else if (key_we) begin
                m_pad[key_index] = key_data;
                m_iss[key_index] = 1'b0;
            end
            if (acc) begin
                s    = in_index;
                m_ov = 1'b1;
                m_oi = in_index;
                m_oe = 1'b1;
                m_od = 8'h00;
                if (!in_decrypt && !m_iss[s]) begin
                    m_od = in_data ^ m_pad[s];
                    m_oe = 1'b0;
                    m_iss[s] = 1'b1;
                end
                if (in_decrypt && m_iss[s]) begin
                    m_od = in_data ^ m_pad[s];
                    m_oe = 1'b0;
                    m_pad[s] = draw;
                    m_iss[s] = 1'b0;
                    m_last_draw = draw;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
        @(negedge clk);
        check_eq("out_valid", out_valid, m_ov);
        if (m_ov || was_rst) begin
            check_eq("out_data", out_data, m_od);
            check_eq("out_index", out_index, m_oi);
            check_eq("out_err", out_err, m_oe);
        end
    endtask

    task automatic req(input bit dec, input logic [2:0] idx, input logic [7:0] data);
        in_valid = 1'b1; in_decrypt = dec; in_index = idx; in_data = data;
        step();
        in_valid = 1'b0;
    endtask

    task automatic kload(input logic [2:0] idx, input logic [7:0] data);
        key_we = 1'b1; key_index = idx; key_data = data;
        step();
        key_we = 1'b0;
    endtask

    int         busy_cnt;
    logic [7:0] held;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; key_we = 1'b0; out_ready = 1'b1;
        in_data = 8'h00; key_data = 8'h00; in_index = 3'd0; key_index = 3'd0;
        r16 = 1'b1; v16 = 1'b0; dec16 = 1'b0; kwe16 = 1'b0; ordy16 = 1'b1;
        d16 = 16'h0000; kd16 = 16'h0000; i16 = 2'd0; ki16 = 2'd0;
        m_last_draw = 8'h00;
        model_reset();
        @(negedge clk);

        // Reset and INIT fill
        repeat (2) step();
        rst = 1'b0;
        check_eq("rst_busy", busy_init, 1'b1);
        repeat (DEPTH) step();
        #1 check_eq("ready_after_init", in_ready, 1'b1);
        req(1'b0, 3'd0, 8'h00);
        check_eq("slot0_pad", out_data, 8'hE1);
        req(1'b0, 3'd1, 8'h00);
        check_eq("slot1_pad", out_data, 8'h70);

        // Round trip and refill
        kload(3'd3, 8'h5A);
        req(1'b0, 3'd3, 8'h3C);
        check_eq("rt_enc", out_data, 8'h66);
        check_eq("rt_idx", out_index, 3'd3);
        check_eq("rt_err", out_err, 1'b0);
        req(1'b1, 3'd3, 8'h66);
        check_eq("rt_dec", out_data, 8'h3C);
        check_eq("rt_dec_err", out_err, 1'b0);
        req(1'b0, 3'd3, 8'h00);
        check_eq("refill_err", out_err, 1'b0);
        check_eq("refill_pad", out_data, m_last_draw);

        // Reuse protection
        kload(3'd5, 8'h11);
        req(1'b0, 3'd5, 8'h22);
        check_eq("reuse_first", out_data, 8'h33);
        req(1'b0, 3'd5, 8'h22);
        check_eq("reuse_err", out_err, 1'b1);
        check_eq("reuse_data", out_data, 8'h00);
        req(1'b1, 3'd2, 8'h44);
        check_eq("fresh_dec_err", out_err, 1'b1);
        check_eq("fresh_dec_data", out_data, 8'h00);

        // Key load collides with a request: request waits one cycle
        in_valid = 1'b1; in_decrypt = 1'b0; in_index = 3'd4; in_data = 8'hF0;
        key_we = 1'b1; key_index = 3'd4; key_data = 8'h0F;
        step();
        key_we = 1'b0;
        step();
        check_eq("kcollide_data", out_data, 8'hFF);
        in_valid = 1'b0;

        // Backpressure
        out_ready = 1'b0;
        req(1'b0, 3'd6, 8'hA5);
        held = m_od;
        in_valid = 1'b1; in_index = 3'd7; in_data = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("bp_valid", out_valid, 1'b1);
            check_eq("bp_stable", out_data, held);
            #1 check_eq("bp_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_index = 3'(k + 6);
            step();
        end
        in_valid = 1'b0;
        step();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            key_we     = ($urandom_range(0, 9) == 0);
            key_index  = 3'($urandom_range(0, 7));
            key_data   = 8'($urandom);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_index   = 3'($urandom_range(0, 7));
            in_decrypt = $urandom_range(0, 1) == 1;
            in_data    = 8'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        key_we = 1'b0; in_valid = 1'b0;

        // Reset mid-stream with a pending result
        out_ready = 1'b0;
        step();
        req(1'b0, 3'd2, 8'h77);
        rst = 1'b1;
        step();
        check_eq("midrst_valid", out_valid, 1'b0);
        check_eq("midrst_busy", busy_init, 1'b1);
        rst = 1'b0; out_ready = 1'b1;
        repeat (DEPTH) step();
        req(1'b0, 3'd0, 8'h00);
        check_eq("midrst_slot0", out_data, 8'hE1);

        // 16-bit data, 4-slot instance
        repeat (2) @(negedge clk);
        r16 = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!busy16) break;
            busy_cnt++;
            @(negedge clk);
        end
        check_eq("w16_init_len", busy_cnt, 4);
        check_eq("w16_ready", rdy16, 1'b1);
        v16 = 1'b1; i16 = 2'd0; d16 = 16'h0000;
        @(negedge clk);
        v16 = 1'b0;
        check_eq("w16_valid", ov16, 1'b1);
        check_eq("w16_slot0", od16, 16'hACE1);
        ordy16 = 1'b0; v16 = 1'b1; i16 = 2'd1;
        @(negedge clk);
        v16 = 1'b0;
        check_eq("w16_pending", ov16, 1'b1);
        r16 = 1'b1;
        @(negedge clk);
        r16 = 1'b0;
        check_eq("w16_rst_valid", ov16, 1'b0);
        check_eq("w16_rst_busy", busy16, 1'b1);
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!busy16) break;
            busy_cnt++;
            @(negedge clk);
        end
        check_eq("w16_reinit_len", busy_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
